// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants for the instruction fetch controller: FSM encodings,
// reset PC, and the legacy enable/stall-index constants.
package inst_fetch_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC00000;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic CHIP_ENABLE = 1'b1;

    // Stall vector bit positions; ID is the stage that consumes inst_o.
    localparam int STALL_PC = 0;
    localparam int STALL_ID = 1;

endpackage

// File: rtl/inst_fetch_buf.sv
// Single-entry holding register for an instruction that returned while
// decode was stalled. Clear wins over load.
module inst_fetch_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer for an SRAM-like bus (req/addr_ok/data_ok).
// Optional misaligned-PC trap: define FETCH_ADEL_CHECK_EN to add fetch_adel_o.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_ce_i,
    input  logic              redirect_i,
    input  logic [5:0]        stall_i,
    output logic              stallreq_o,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [31:0]       inst_rdata_i,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o
`ifdef FETCH_ADEL_CHECK_EN
    ,
    output logic              fetch_adel_o
`endif
);

    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic        load_addr;
    logic        deliver_rdata;
    logic        deliver_buf;
    logic        buf_load;
    logic        buf_clr;
    logic        buf_valid;
    logic [31:0] buf_data;
    logic        ce;
    logic        id_stall;
`ifdef FETCH_ADEL_CHECK_EN
    logic        adel_fire;
`endif

    logic unused_stall_bits;
    assign unused_stall_bits = &{1'b0, stall_i[5:2], stall_i[STALL_PC]};

    assign ce       = (pc_ce_i == CHIP_ENABLE);
    assign id_stall = stall_i[STALL_ID];

    inst_fetch_buf #(.W(32)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clr   (buf_clr),
        .din   (inst_rdata_i),
        .dout  (buf_data),
        .valid (buf_valid)
    );

    // pc_i is expected to already carry the redirect target in the cycle
    // redirect_i is high, so every load below samples the address to fetch.
    always_comb begin
        state_next    = state_reg;
        load_addr     = 1'b0;
        deliver_rdata = 1'b0;
        deliver_buf   = 1'b0;
        buf_load      = 1'b0;
        buf_clr       = 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
        adel_fire     = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (ce) begin
                    state_next = ST_REQ;
                    load_addr  = 1'b1;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    if (inst_addr_ok_i) state_next = ST_DISCARD;
                    else                load_addr  = 1'b1;
                end else if (!ce) begin
                    state_next = inst_addr_ok_i ? ST_DISCARD : ST_IDLE;
                end else if (inst_addr_ok_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    if (inst_data_ok_i) begin
                        state_next = ST_REQ;
                        load_addr  = 1'b1;
                    end else begin
                        state_next = ST_DISCARD;
                    end
                end else if (inst_data_ok_i) begin
                    if (!ce) begin
                        state_next = ST_IDLE;
                    end else if (id_stall) begin
                        buf_load   = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        deliver_rdata = 1'b1;
                        state_next    = ST_REQ;
                        load_addr     = 1'b1;
                    end
                end else if (!ce) begin
                    state_next = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    buf_clr    = 1'b1;
                    state_next = ST_REQ;
                    load_addr  = 1'b1;
                end else if (!ce) begin
                    buf_clr    = 1'b1;
                    state_next = ST_IDLE;
                end else if (!id_stall && buf_valid) begin
                    deliver_buf = 1'b1;
                    buf_clr     = 1'b1;
                    state_next  = ST_REQ;
                    load_addr   = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (inst_data_ok_i) begin
                    state_next = ce ? ST_REQ : ST_IDLE;
                    load_addr  = ce;
                end
            end
            default: state_next = ST_IDLE;
        endcase
`ifdef FETCH_ADEL_CHECK_EN
        // A misaligned target never reaches the bus; if an instruction is
        // being delivered this cycle, the trap is raised from IDLE next cycle.
        if (load_addr && (pc_i[1:0] != 2'b00)) begin
            load_addr  = 1'b0;
            state_next = ST_IDLE;
            adel_fire  = !(deliver_rdata || deliver_buf);
        end
`endif
    end

    assign stallreq_o = (state_reg == ST_REQ) || (state_reg == ST_DISCARD) ||
                        ((state_reg == ST_WAIT) && !(inst_data_ok_i && !redirect_i));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            inst_req_o   <= 1'b0;
            inst_addr_o  <= RESET_PC;
            inst_o       <= 32'h0;
            inst_valid_o <= 1'b0;
`ifdef FETCH_ADEL_CHECK_EN
            fetch_adel_o <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            inst_req_o   <= (state_next == ST_REQ);
            if (load_addr) inst_addr_o <= pc_i;
            inst_valid_o <= deliver_rdata || deliver_buf;
            if (deliver_rdata)    inst_o <= inst_rdata_i;
            else if (deliver_buf) inst_o <= buf_data;
`ifdef FETCH_ADEL_CHECK_EN
            fetch_adel_o <= adel_fire;
            if (adel_fire) begin
                inst_o       <= 32'h0;
                inst_valid_o <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Sequences instruction fetch for the PC register over an SRAM-like instruction bus (req/addr_ok/data_ok).
- Raises an IF stall request while a fetch is outstanding and buffers a returned instruction while decode is stalled.
- Discards in-flight fetches after a branch or CP0 redirect.
- Sits between the PC register, the pipeline stall controller and the instruction-memory port; feeds the IF/ID register.

Parameters:
- ADDR_W, 32, instruction address width.
- RESET_PC, 32'hBFC00000, address presented on inst_addr_o after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_i  input  32  current PC from the PC register.
- pc_ce_i  input  1  PC chip enable; no fetch is issued while 0.
- redirect_i  input  1  branch_flag or cp0_branch_flag pulse; the PC changes on this edge.
- stall_i  input  6  pipeline stall vector; stall_i[1] high means ID is not accepting.
- stallreq_o  output  1  IF stall request to the stall controller.
- inst_req_o  output  1  bus request.
- inst_addr_o  output  32  bus address.
- inst_addr_ok_i  input  1  address accepted this cycle.
- inst_data_ok_i  input  1  read data valid this cycle.
- inst_rdata_i  input  32  read data.
- inst_o  output  32  instruction to IF/ID.
- inst_valid_o  output  1  inst_o is valid for the current pc_i.

Behaviour:
- One clock domain; reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, inst_req_o=0, inst_addr_o=RESET_PC, inst_o=0, inst_valid_o=0, internal buffer empty.
- All outputs are registered except stallreq_o, which is combinational from state and inst_data_ok_i.
- At most one outstanding transaction.
- States and transitions:
  - IDLE: if pc_ce_i=1, go to REQ and load inst_addr_o<=pc_i.
  - REQ: inst_req_o=1.
    - addr_ok=1 and no redirect: go to WAIT.
    - redirect_i=1 without addr_ok: stay in REQ and reload inst_addr_o from the new pc_i next cycle. The request was not yet accepted, so the change is legal.
    - redirect_i=1 with addr_ok: go to DISCARD.
    - inst_addr_o must stay stable while in REQ, except on the redirect reload.
  - WAIT: inst_req_o=0.
    - data_ok=1 and redirect_i=0, with stall_i[1]=0: drive inst_o=rdata and inst_valid_o=1 next cycle, then go to REQ for the next pc_i.
    - Same, but with stall_i[1]=1: latch rdata into the buffer and go to HOLD.
    - redirect_i=1 with no data_ok: go to DISCARD.
    - redirect_i=1 with data_ok in the same cycle: drop the data and go to REQ with the new pc_i.
  - HOLD: keep the buffered instruction.
    - When stall_i[1]=0: present it with inst_valid_o=1 for one cycle, then go to REQ.
    - redirect_i in HOLD: clear the buffer and go to REQ.
  - DISCARD: wait for data_ok, drop the data (inst_valid_o stays 0), then go to REQ with the current pc_i.
- stallreq_o=1 in REQ, WAIT and DISCARD, except in a WAIT cycle where data_ok=1 and redirect_i=0. It is 0 in IDLE and HOLD; in HOLD the pipeline stall already holds the PC.
- inst_valid_o is a single-cycle pulse per delivered instruction; it is 0 in the cycle after any redirect.
- Latency without wait states: REQ (addr_ok) -> WAIT (data_ok) -> inst_valid_o, i.e. 2 cycles from request to delivery.
- pc_ce_i falling mid-transaction: finish the transaction as in DISCARD, then go to IDLE.
- rst mid-transaction: immediate return to reset values. The bus master is reset with the same rst, so no late data_ok is expected.

Optional Feature:
- Macro: FETCH_ADEL_CHECK_EN.
- With the macro defined:
  - In IDLE or REQ, if pc_i[1:0]!=2'b00, issue no bus request.
  - Deliver inst_o=32'h0 with inst_valid_o=1 and fetch_adel_o=1 for one cycle, then accept the next pc_i. fetch_adel_o is an extra 1-bit output, reset 0, which the exception unit consumes.
  - stallreq_o=0 during that cycle.
- Without the macro: the fetch_adel_o port is absent, and misaligned addresses are passed to the bus unchanged.

Decomposition:
- Shared package / defines.v:
  - state encodings (IDLE, REQ, WAIT, HOLD, DISCARD, 3-bit);
  - RESET_PC constant;
  - existing RstEnable, ChipEnable and stall-bit index constants, with the ID stall bit at index 1.
- One natural sub-module: inst_fetch_buf, a single-entry instruction holding register with load/clear/valid.
- The FSM and the bus drive stay in the top module.

Test Plan:
- Reset release with pc_i=32'hBFC00000 and zero-wait bus (addr_ok in REQ, data_ok the next cycle, rdata=32'h24080001): inst_addr_o=BFC00000, inst_valid_o pulses with inst_o=24080001 2 cycles after req, and stallreq_o is high only during REQ.
- data_ok arrives while stall_i[1]=1 for 3 cycles: state goes to HOLD, inst_valid_o stays 0 for those 3 cycles, and inst_o is delivered the cycle after stall_i[1] falls with no new bus request in between.
- redirect_i in WAIT (new pc_i=32'hBFC00100) with data_ok 2 cycles later: the data is dropped and inst_valid_o stays 0. The next request addresses BFC00100, and stallreq_o stays high throughout.
- redirect_i in REQ before addr_ok: inst_addr_o changes to the new pc_i next cycle while inst_req_o stays 1, and exactly one data_ok is delivered, for the new address.
- rst asserted while in WAIT: all outputs take reset values in the same cycle (asynchronous reset), and after release the fetch restarts from BFC00000.
- With FETCH_ADEL_CHECK_EN defined, pc_i=32'hBFC00002: no inst_req_o, and a single cycle of fetch_adel_o=1 with inst_valid_o=1 and inst_o=0.
